// File: rtl/quantum_pkg.sv
// Shared gate opcodes and sequencer state encoding, common to the gate
// sequencer and the quantum controller.
package quantum_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_H   = 3'b001;
  localparam logic [2:0] OP_X   = 3'b010;
  localparam logic [2:0] OP_Z   = 3'b011;
  localparam logic [2:0] OP_Y   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_e;

  function automatic logic is_gate_op(input logic [2:0] op);
    return (op >= OP_H) && (op <= OP_Y);
  endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Command/status link between the gate sequencer (master) and the
// quantum controller (slave).
interface gate_sequencer_if;
  logic [2:0]  cmd_gate;
  logic        cmd_execute;
  logic        gate_busy;
  logic [31:0] display_alpha;
  logic [31:0] display_beta;

  modport master (output cmd_gate, cmd_execute,
                  input  gate_busy, display_alpha, display_beta);
  modport slave  (input  cmd_gate, cmd_execute,
                  output gate_busy, display_alpha, display_beta);
endinterface

// File: rtl/gate_prog_mem.sv
// Program storage for the gate sequencer: DEPTH x 3-bit opcodes,
// synchronous write, asynchronous read.
module gate_prog_mem #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [2:0]               rd_data
);

  logic [2:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/gate_sequencer.sv
// Replays a stored gate program to the quantum controller, one pulse per gate.
// Optional GATE_SEQ_LOOP_EN adds loop_count: replay the program loop_count+1 times.
module gate_sequencer
  import quantum_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_wr_en,
  input  logic [2:0]               prog_wr_data,
  input  logic                     prog_clear,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic                     prog_full,
  input  logic                     start,
  input  logic                     abort,
`ifdef GATE_SEQ_LOOP_EN
  input  logic [3:0]               loop_count,
`endif
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     seq_error,
  output logic [$clog2(DEPTH)-1:0] gate_index,
  gate_sequencer_if.master         gif,
  output logic [31:0]              last_alpha,
  output logic [31:0]              last_beta
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  seq_state_e    state_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] index_q, adv_index;
  seq_state_e    adv_state;
  logic [2:0]    cmd_gate_q, op;
  logic          cmd_exec_q, error_q, prog_we, last_entry;
  logic [TW-1:0] timer_q;
  logic [31:0]   alpha_q, beta_q;
`ifdef GATE_SEQ_LOOP_EN
  logic [3:0]    loops_q;
  logic          adv_wrap;
`endif

  gate_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (prog_we),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (prog_wr_data),
    .rd_addr (index_q),
    .rd_data (op)
  );

  // Program edits only while idle; clear wins over a simultaneous push.
  always_comb begin
    count_d = count_q;
    prog_we = 1'b0;
    if (state_q == ST_IDLE) begin
      if (prog_clear) begin
        count_d = '0;
      end else if (prog_wr_en && !prog_full) begin
        prog_we = 1'b1;
        count_d = count_q + CW'(1);
      end
    end
  end

  assign last_entry = ({1'b0, index_q} == (count_q - CW'(1)));

  always_comb begin
    adv_index = index_q + AW'(1);
    adv_state = ST_FETCH;
`ifdef GATE_SEQ_LOOP_EN
    adv_wrap  = 1'b0;
`endif
    if (last_entry) begin
      adv_index = '0;
`ifdef GATE_SEQ_LOOP_EN
      if (loops_q == 4'd0) adv_state = ST_DONE;
      else                 adv_wrap  = 1'b1;
`else
      adv_state = ST_DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      index_q    <= '0;
      cmd_gate_q <= OP_NOP;
      cmd_exec_q <= 1'b0;
      error_q    <= 1'b0;
      timer_q    <= '0;
      alpha_q    <= 32'h0001_0000;
      beta_q     <= '0;
`ifdef GATE_SEQ_LOOP_EN
      loops_q    <= '0;
`endif
    end else begin
      count_q    <= count_d;
      cmd_exec_q <= 1'b0;
      if (abort && state_q != ST_IDLE && state_q != ST_DONE) begin
        state_q <= ST_DONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (count_q != '0) begin
                error_q <= 1'b0;
                index_q <= '0;
                state_q <= ST_FETCH;
`ifdef GATE_SEQ_LOOP_EN
                loops_q <= loop_count;
`endif
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_FETCH: begin
            if (op == OP_NOP) begin
              index_q <= adv_index;
              state_q <= adv_state;
`ifdef GATE_SEQ_LOOP_EN
              if (adv_wrap) loops_q <= loops_q - 4'd1;
`endif
            end else if (is_gate_op(op)) begin
              state_q <= ST_PULSE;
            end else begin
              error_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_PULSE: begin
            // Hold off while the controller is still finishing a previous gate.
            if (!gif.gate_busy) begin
              cmd_gate_q <= op;
              cmd_exec_q <= 1'b1;
              timer_q    <= TW'(ACK_TIMEOUT - 1);
              state_q    <= ST_WAIT_ACK;
            end
          end
          ST_WAIT_ACK: begin
            if (gif.gate_busy) begin
              state_q <= ST_WAIT_DONE;
            end else if (timer_q == '0) begin
              error_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          ST_WAIT_DONE: begin
            if (!gif.gate_busy) begin
              alpha_q <= gif.display_alpha;
              beta_q  <= gif.display_beta;
              index_q <= adv_index;
              state_q <= adv_state;
`ifdef GATE_SEQ_LOOP_EN
              if (adv_wrap) loops_q <= loops_q - 4'd1;
`endif
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign prog_count      = count_q;
  assign prog_full       = (count_q == CW'(DEPTH));
  assign seq_busy        = (state_q != ST_IDLE);
  assign seq_done        = (state_q == ST_DONE);
  assign seq_error       = error_q;
  assign gate_index      = index_q;
  assign gif.cmd_gate    = cmd_gate_q;
  assign gif.cmd_execute = cmd_exec_q;
  assign last_alpha      = alpha_q;
  assign last_beta       = beta_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: a simple controller model answers pulses,
// and a program-level model predicts pulse sequences, counts and errors.
module tb_gate_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset, prog_wr_en, prog_clear, start, abort;
  logic [2:0]    prog_wr_data;
  logic [AW:0]   prog_count;
  logic          prog_full, seq_busy, seq_done, seq_error;
  logic [AW-1:0] gate_index;
  logic [31:0]   last_alpha, last_beta;

  gate_sequencer_if gif();

  gate_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .prog_wr_en(prog_wr_en), .prog_wr_data(prog_wr_data), .prog_clear(prog_clear),
    .prog_count(prog_count), .prog_full(prog_full),
    .start(start), .abort(abort),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
    .gate_index(gate_index), .gif(gif.master),
    .last_alpha(last_alpha), .last_beta(last_beta)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // program-level model
  logic [2:0] mdl_prog [DEPTH];
  int         mdl_count   = 0;
  bit         mdl_running = 0;
  logic [2:0] exp_ops [$];
  bit         exp_err = 0;
  int         exp_lim = 0;
  int         pulse_idx = 0;
  int         done_cnt  = 0;
  bit         chk_en    = 0;
  logic       prev_exec = 1'b0;

  // controller model
  bit          ctl_mute = 0;
  int          ctl_n = 0;
  logic [31:0] ctl_alpha_last = 32'h0001_0000;
  logic [31:0] ctl_beta_last  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    gif.gate_busy     = 1'b0;
    gif.display_alpha = 32'h0001_0000;
    gif.display_beta  = 32'h0;
    forever begin
      @(negedge clk);
      if (gif.cmd_execute === 1'b1 && !ctl_mute) begin
        gif.gate_busy = 1'b1;
        repeat (3) @(negedge clk);
        ctl_n++;
        gif.display_alpha = 32'h0001_0000 + 32'(ctl_n << 8) + 32'(gif.cmd_gate);
        gif.display_beta  = 32'hBEEF_0000 ^ 32'(ctl_n);
        ctl_alpha_last    = gif.display_alpha;
        ctl_beta_last     = gif.display_beta;
        gif.gate_busy     = 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("prog_count", 32'(prog_count), 32'(mdl_count));
        chk("prog_full", 32'(prog_full), 32'(mdl_count == DEPTH));
        if (gif.cmd_execute === 1'b1) begin
          chk("pulse_expected", 32'(pulse_idx < exp_lim), 32'd1);
          if (pulse_idx < exp_lim) chk("cmd_gate", 32'(gif.cmd_gate), 32'(exp_ops[pulse_idx]));
          chk("exec_single_cycle", 32'(prev_exec), 32'd0);
          pulse_idx++;
        end
        if (seq_done === 1'b1) done_cnt++;
      end
      prev_exec = gif.cmd_execute;
    end
  end

  task automatic prog_write(input logic [2:0] d, input bit clr);
    @(negedge clk);
    prog_wr_en = !clr; prog_clear = clr; prog_wr_data = d;
    @(posedge clk);
    if (!mdl_running) begin
      if (clr) mdl_count = 0;
      else if (mdl_count < DEPTH) begin
        mdl_prog[mdl_count] = d;
        mdl_count++;
      end
    end
    #1 prog_wr_en = 1'b0; prog_clear = 1'b0;
  endtask

  task automatic start_run();
    exp_ops.delete();
    exp_err = 0;
    for (int i = 0; i < mdl_count; i++) begin
      if (mdl_prog[i] == 3'd0) continue;
      if (mdl_prog[i] > 3'd4) begin exp_err = 1; break; end
      exp_ops.push_back(mdl_prog[i]);
    end
    exp_lim = exp_ops.size(); pulse_idx = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    mdl_running = 1;
    #1 start = 1'b0;
  endtask

  task automatic finish_run(input bit timeout);
    int k = 0;
    while (done_cnt == 0 && k < 400) begin @(negedge clk); k++; end
    chk("run_finished", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
    mdl_running = 0;
    chk("pulse_count", 32'(pulse_idx), 32'(exp_lim));
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("seq_error", 32'(seq_error), 32'(exp_err | timeout));
    chk("seq_busy_idle", 32'(seq_busy), 32'd0);
    chk("last_alpha", last_alpha, ctl_alpha_last);
    chk("last_beta", last_beta, ctl_beta_last);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_count"}, 32'(prog_count), 32'd0);
    chk({tag, "_index"}, 32'(gate_index), 32'd0);
    chk({tag, "_cmd_gate"}, 32'(gif.cmd_gate), 32'd0);
    chk({tag, "_cmd_exec"}, 32'(gif.cmd_execute), 32'd0);
    chk({tag, "_busy"}, 32'(seq_busy), 32'd0);
    chk({tag, "_done"}, 32'(seq_done), 32'd0);
    chk({tag, "_error"}, 32'(seq_error), 32'd0);
    chk({tag, "_alpha"}, last_alpha, 32'h0001_0000);
    chk({tag, "_beta"}, last_beta, 32'h0);
  endtask

  task automatic wait_exec(output bit seen);
    int k = 0;
    while (gif.cmd_execute !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    seen = (gif.cmd_execute === 1'b1);
    chk("exec_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    bit seen;
    int n;
    bit err_early;
    reset = 1'b1; prog_wr_en = 1'b0; prog_clear = 1'b0; prog_wr_data = 3'd0;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("por");
    chk_en = 1;

    // H,X,H with writes/clear attempted mid-run
    prog_write(3'd1, 0); prog_write(3'd2, 0); prog_write(3'd1, 0);
    start_run();
    prog_write(3'd4, 0); prog_write(3'd0, 1);
    finish_run(0);
    chk("hxh_pulses", 32'(pulse_idx), 32'd3);
    chk("hxh_alpha_lit", last_alpha, 32'h0001_0301);
    chk("hxh_beta_lit", last_beta, 32'hBEEF_0003);

    // replay unchanged program
    start_run(); finish_run(0);
    chk("replay_alpha_lit", last_alpha, 32'h0001_0601);

    // empty program goes straight to done
    prog_write(3'd0, 1);
    start_run(); finish_run(0);
    chk("empty_pulses", 32'(pulse_idx), 32'd0);

    // NOP then Z
    prog_write(3'd0, 0); prog_write(3'd3, 0);
    start_run(); finish_run(0);
    chk("nop_pulses", 32'(pulse_idx), 32'd1);

    // invalid opcode at entry 1
    prog_write(3'd0, 1); prog_write(3'd1, 0); prog_write(3'd6, 0);
    start_run(); finish_run(0);
    chk("badop_pulses", 32'(pulse_idx), 32'd1);
    chk("badop_error", 32'(seq_error), 32'd1);

    // ack timeout with a silent controller
    prog_write(3'd0, 1); prog_write(3'd1, 0);
    ctl_mute = 1;
    start_run();
    wait_exec(seen);
    n = 0; err_early = 0;
    do begin
      @(negedge clk); n++;
      if (seq_done !== 1'b1 && seq_error === 1'b1) err_early = 1;
    end while (seq_done !== 1'b1 && n < 20);
    chk("ack_timeout_cycles", 32'(n), 32'd4);
    chk("no_early_error", 32'(err_early), 32'd0);
    finish_run(1);
    ctl_mute = 0;

    // overfill: DEPTH+1 writes
    prog_write(3'd0, 1);
    for (int i = 0; i <= DEPTH; i++) prog_write(3'd1, 0);
    @(negedge clk);
    chk("full_count_lit", 32'(prog_count), 32'(DEPTH));
    chk("full_flag_lit", 32'(prog_full), 32'd1);
    start_run(); finish_run(0);
    chk("full_pulses", 32'(pulse_idx), 32'(DEPTH));

    // abort while the controller is busy
    prog_write(3'd0, 1); prog_write(3'd1, 0); prog_write(3'd2, 0); prog_write(3'd1, 0);
    start_run();
    wait_exec(seen);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_done_next", 32'(seq_done), 32'd1);
    repeat (12) @(negedge clk);
    mdl_running = 0;
    chk("abort_pulses", 32'(pulse_idx), 32'd1);
    chk("abort_done_once", 32'(done_cnt), 32'd1);

    // reset in the middle of a run
    start_run();
    wait_exec(seen);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    mdl_count = 0; mdl_running = 0; exp_lim = pulse_idx;
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("midrun");
    repeat (15) @(negedge clk);
    chk("post_reset_pulses", 32'(pulse_idx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning program storage entries (power of two, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning max cycles to wait for gate_busy to rise after a pulse.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports prog_wr_en  in  1  push opcode; prog_wr_data  in  3  gate opcode; prog_clear  in  1  empty program.
REQ-005 SHALL have ports prog_count  out  $clog2(DEPTH)+1  stored entries; prog_full  out  1  count==DEPTH.
REQ-006 SHALL have ports start  in  1  run program; abort  in  1  stop run; seq_busy  out  1  run active; seq_done  out  1  one-cycle completion pulse; seq_error  out  1  sticky fault.
REQ-007 SHALL have ports gate_index  out  $clog2(DEPTH)  entry in progress; cmd_gate  out  3  opcode to controller; cmd_execute  out  1  execute pulse; gate_busy  in  1  controller busy.
REQ-008 SHALL have ports display_alpha, display_beta  in  32  Q16.16 controller state; last_alpha, last_beta  out  32  state captured after last completed gate.

Function
REQ-009 SHALL accept prog_wr_en only in IDLE with prog_full low; otherwise ignore it with no storage change.
REQ-010 SHALL give prog_clear priority over prog_wr_en in the same cycle (count->0), accepted only in IDLE.
REQ-011 SHALL retain the program after a run so start replays it unchanged.
REQ-012 SHALL use states IDLE, FETCH, PULSE, WAIT_ACK, WAIT_DONE, DONE.
REQ-013 SHALL, on start in IDLE with prog_count>0, clear seq_error, set index 0, go to FETCH; with count==0 go to DONE directly; ignore start outside IDLE.
REQ-014 SHALL in FETCH: opcode 000 = NOP, skipped in 1 cycle; 001 H, 010 X, 011 Z, 100 Y go to PULSE; 101-111 set seq_error and go to DONE.
REQ-015 SHALL in PULSE drive cmd_gate = opcode and cmd_execute = 1 for exactly one cycle; cmd_gate holds its value until the next PULSE.
REQ-016 SHALL first wait in PULSE while gate_busy is already high (no pulse issued until it is low).
REQ-017 SHALL in WAIT_ACK wait for gate_busy=1, then go to WAIT_DONE; after ACK_TIMEOUT cycles without it, set seq_error and go to DONE.
REQ-018 SHALL on gate_busy falling in WAIT_DONE capture display_alpha/beta into last_alpha/beta, then advance index; last entry -> DONE, else FETCH.
REQ-019 SHALL in DONE assert seq_done for one cycle and return to IDLE next cycle.
REQ-020 SHALL on abort in any non-IDLE state go to DONE next cycle without issuing further pulses; an in-flight controller gate is not cancelled.
REQ-021 SHALL hold seq_busy = 1 in every state except IDLE.

Reset
REQ-022 SHALL on reset: state IDLE, prog_count 0, index 0, cmd_gate 000, cmd_execute 0, seq_busy 0, seq_done 0, seq_error 0, last_alpha 32'h0001_0000, last_beta 0.
REQ-023 SHALL let reset mid-run override everything within one cycle, including a pending pulse.

Configuration
REQ-024 SHALL with GATE_SEQ_LOOP_EN defined add input loop_count (4 bits, sampled at start) and replay the full program loop_count+1 times before DONE; without it, run once and omit the port.

Structure
REQ-025 SHALL place gate opcode constants (NOP, H, X, Z, Y) and state encoding in shared package quantum_pkg used by quantum_controller as well.
REQ-026 SHALL implement storage as sub-module gate_prog_mem (DEPTH x 3 bits, sync write, async read).

Verification
REQ-027 Bench SHALL check: reset, load H,X,H, start -> 3 single-cycle cmd_execute pulses with cmd_gate 001,010,001; seq_done once; last_alpha/beta match controller.
REQ-028 Bench SHALL check: program [000,011] -> exactly one pulse (Z); NOP adds no pulse.
REQ-029 Bench SHALL check: opcode 110 at entry 1 -> one pulse for entry 0, then seq_error=1, seq_done pulse.
REQ-030 Bench SHALL check: gate_busy held low with ACK_TIMEOUT=4 -> seq_error after 4 WAIT_ACK cycles.
REQ-031 Bench SHALL check: DEPTH+1 writes -> prog_count=DEPTH, prog_full=1, extra write dropped; writes during run ignored.
REQ-032 Bench SHALL check: abort in WAIT_DONE -> no further pulses, seq_done next cycle; then reset mid-run -> all outputs at reset values.
